// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// slave = arbiter side; master = requester/memory side.
interface dmem_arbiter_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  req0;
   logic                  req1;
   logic                  we0;
   logic                  we1;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [31:0]           wdata0;
   logic [31:0]           wdata1;
   logic                  done0;
   logic                  done1;
   logic [31:0]           rdata;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  mem_we;
   logic                  mem_re;
   logic [31:0]           mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output done0, done1, rdata, busy, mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  done0, done1, rdata, busy, mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: port 0 has priority,
// a saturating starvation counter forces port 1 through under contention.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner
// ISSUE | drives the memory for exactly one cycle
// WAIT  | remaining memory latency (skipped when MEM_LATENCY == 1)
// DONE  | one-cycle completion pulse to the owner
module dmem_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic           CLK,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);
   localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
   localparam int SW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
   localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [SW-1:0]         starve_q, starve_d;
   logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic                  grant1;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         starve_q   <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         starve_q   <= starve_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      starve_d   = starve_q;
      wait_cnt_d = wait_cnt_q;
      grant1     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               grant1  = bus.req1 && (!bus.req0 || (starve_q == STARVE_MAX));
               owner_d = grant1;
               we_d    = grant1 ? bus.we1    : bus.we0;
               addr_d  = grant1 ? bus.addr1  : bus.addr0;
               wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
               if (grant1) begin
                  starve_d = '0;
               end else if (bus.req1 && (starve_q != STARVE_MAX)) begin
                  starve_d = starve_q + 1'b1;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // WAIT covers the latency cycles after ISSUE; with latency 1 the
            // data is already valid at the end of ISSUE.
            if (MEM_LATENCY == 1) begin
               state_d = DONE;
               if (!we_q) rdata_d = bus.mem_rdata;
            end else begin
               wait_cnt_d = WAIT_LOAD;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = DONE;
               if (!we_q) rdata_d = bus.mem_rdata;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.mem_we    = (state_q == ISSUE) &&  we_q;
   assign bus.mem_re    = (state_q == ISSUE) && !we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.done0     = (state_q == DONE) && !owner_q;
   assign bus.done1     = (state_q == DONE) &&  owner_q;
   assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-timing reference model; two extra builds check latency 1 and 4.
module tb_dmem_arbiter;
   localparam int AW  = 16;
   localparam int LAT = 2;
   localparam int SL  = 4;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus    ();
   dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus_l1 ();
   dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus_l4 ();

   dmem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
      .CLK(CLK), .reset(reset), .bus(bus.slave));
   dmem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(1), .STARVE_LIMIT(SL)) dut_l1 (
      .CLK(CLK), .reset(reset), .bus(bus_l1.slave));
   dmem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(4), .STARVE_LIMIT(SL)) dut_l4 (
      .CLK(CLK), .reset(reset), .bus(bus_l4.slave));

   int n_tests = 0;
   int n_fail  = 0;

   // memory models: read data is valid only in the cycle the arbiter samples it
   logic [31:0]   mem [0:255];
   int            rd_cnt  = -1;
   int            rd_cnt1 = -1;
   int            rd_cnt4 = -1;
   logic [7:0]    rd_addr  = '0;
   logic [AW-1:0] rd_addr1 = '0;
   logic [AW-1:0] rd_addr4 = '0;

   assign bus.mem_rdata    = (rd_cnt  == 0) ? mem[rd_addr]         : 32'hBAAD_F00D;
   assign bus_l1.mem_rdata = (rd_cnt1 == 0) ? {16'hA5A5, rd_addr1} : 32'hBAAD_F00D;
   assign bus_l4.mem_rdata = (rd_cnt4 == 0) ? {16'hA5A5, rd_addr4} : 32'hBAAD_F00D;

   // reference model state (transaction level)
   logic [31:0]   ref_mem [0:255];
   bit            pend;
   int            acc_t;
   int            cyc;
   int            starve;
   logic          m_owner;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [AW-1:0] last_addr;
   logic [31:0]   last_wdata;
   logic [31:0]   exp_rdata;
   int            grants [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      pend       = 1'b0;
      starve     = 0;
      last_addr  = '0;
      last_wdata = '0;
      exp_rdata  = '0;
   endtask

   task automatic idle_inputs();
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      bus_l1.req0 = 0; bus_l1.req1 = 0; bus_l1.we0 = 0; bus_l1.we1 = 0;
      bus_l1.addr0 = '0; bus_l1.addr1 = '0; bus_l1.wdata0 = '0; bus_l1.wdata1 = '0;
      bus_l4.req0 = 0; bus_l4.req1 = 0; bus_l4.we0 = 0; bus_l4.we1 = 0;
      bus_l4.addr0 = '0; bus_l4.addr1 = '0; bus_l4.wdata0 = '0; bus_l4.wdata1 = '0;
   endtask

   // One clock cycle: check main DUT against the model mid-cycle, advance the
   // model with this cycle's inputs, update memories, move to the next cycle.
   task automatic step();
      bit         in_issue, in_done, g1;
      logic [4:0] exp_ctl;
      @(negedge CLK);
      if (pend && cyc >= acc_t + 2 + LAT) pend = 1'b0;
      in_issue = pend && (cyc == acc_t + 1);
      in_done  = pend && (cyc == acc_t + 1 + LAT);
      if (in_done && !m_we) exp_rdata = ref_mem[m_addr[7:0]];
      exp_ctl = {in_done && !m_owner, in_done && m_owner, pend, in_issue && m_we, in_issue && !m_we};
      check("ctl(done0,done1,busy,we,re)",
            {59'd0, bus.done0, bus.done1, bus.busy, bus.mem_we, bus.mem_re}, {59'd0, exp_ctl});
      check("mem_addr",  {48'd0, bus.mem_addr},  {48'd0, last_addr});
      check("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, last_wdata});
      check("rdata",     {32'd0, bus.rdata},     {32'd0, exp_rdata});
      if (in_done) grants.push_back(int'(m_owner));

      if (reset) begin
         model_reset();
      end else if (!pend && (bus.req0 || bus.req1)) begin
         g1 = bus.req1 && (!bus.req0 || starve == SL);
         if (g1) starve = 0;
         else if (bus.req1) starve = (starve == SL) ? SL : starve + 1;
         m_owner    = g1;
         m_we       = g1 ? bus.we1    : bus.we0;
         m_addr     = g1 ? bus.addr1  : bus.addr0;
         m_wdata    = g1 ? bus.wdata1 : bus.wdata0;
         last_addr  = m_addr;
         last_wdata = m_wdata;
         if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
         pend  = 1'b1;
         acc_t = cyc;
      end

      if (bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
      if (rd_cnt >= 0) rd_cnt--;
      if (bus.mem_re) begin rd_cnt = LAT - 1; rd_addr = bus.mem_addr[7:0]; end
      if (rd_cnt1 >= 0) rd_cnt1--;
      if (bus_l1.mem_re) begin rd_cnt1 = 0; rd_addr1 = bus_l1.mem_addr; end
      if (rd_cnt4 >= 0) rd_cnt4--;
      if (bus_l4.mem_re) begin rd_cnt4 = 3; rd_addr4 = bus_l4.mem_addr; end
      cyc++;
      @(posedge CLK); #1;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'h1000_0000 + i;
         ref_mem[i] = 32'h1000_0000 + i;
      end
      mem[16]     = 32'hDEAD_BEEF;
      ref_mem[16] = 32'hDEAD_BEEF;
      model_reset();
      cyc = 0;
      @(posedge CLK); #1;
      step();
      reset = 1'b0;

      // single port-0 read of 0x0010, request dropped in the ISSUE cycle
      repeat (4) step();
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0010;
      step();
      bus.req0 = 0;
      repeat (LAT + 3) step();

      // port-1 write then port-0 read of the same word
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0003; bus.wdata1 = 32'h1234_5678;
      step();
      bus.req1 = 0;
      repeat (LAT + 2) step();
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0003;
      step();
      bus.req0 = 0;
      repeat (LAT + 3) step();

      // reset while in WAIT aborts, then a fresh request completes
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0005; bus.wdata0 = 32'hCAFE_0005;
      step();
      bus.req0 = 0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (2) step();
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0005;
      step();
      bus.req0 = 0;
      repeat (LAT + 3) step();

      // both ports requesting continuously from a clean starvation count
      reset = 1'b1;
      step();
      reset = 1'b0;
      grants.delete();
      bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = 16'h0001; bus.addr1 = 16'h0002;
      repeat (10 * (LAT + 2) + 2) step();
      bus.req0 = 0; bus.req1 = 0;
      repeat (LAT + 3) step();
      if (grants.size() < 10) begin
         check("grant_count", 64'(grants.size()), 64'd10);
      end else begin
         for (int k = 0; k < 10; k++)
            check("grant_order", 64'(grants[k]), (k % 5 == 4) ? 64'd1 : 64'd0);
      end

      // randomized traffic with occasional resets
      repeat (1500) begin
         bus.req0   = ($urandom_range(0, 99) < 55);
         bus.req1   = ($urandom_range(0, 99) < 45);
         bus.we0    = $urandom_range(0, 1) == 1;
         bus.we1    = $urandom_range(0, 1) == 1;
         bus.addr0  = AW'($urandom_range(0, 16));
         bus.addr1  = AW'($urandom_range(0, 16));
         bus.wdata0 = $urandom;
         bus.wdata1 = $urandom;
         reset      = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;
      idle_inputs();
      repeat (LAT + 3) step();

      // latency-1 and latency-4 builds: done timing and captured read data
      bus_l1.req0 = 1; bus_l1.addr0 = 16'h0021;
      bus_l4.req0 = 1; bus_l4.addr0 = 16'h0042;
      step();
      bus_l1.req0 = 0; bus_l4.req0 = 0;
      for (int k = 1; k <= 6; k++) begin
         check("l1_done0", {63'd0, bus_l1.done0}, (k == 2) ? 64'd1 : 64'd0);
         check("l4_done0", {63'd0, bus_l4.done0}, (k == 5) ? 64'd1 : 64'd0);
         if (k == 2) check("l1_rdata", {32'd0, bus_l1.rdata}, 64'h0000_0000_A5A5_0021);
         if (k == 5) check("l4_rdata", {32'd0, bus_l4.rdata}, 64'h0000_0000_A5A5_0042);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
